// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch; tags imem reads with their pc, queues responses in order, hands {instr, instr_pc} to decode.
// Latency: grant in cycle t, rvalid no earlier than t+1, instruction visible to decode the cycle after rvalid (no bypass).
// Backpressure: imem_req drops while DEPTH slots are allocated; decode stalls via instr_ready; redirect flushes and drops stale responses.
// Optional feature macro: IFETCH_MISALIGN_EN (sticky misaligned-target flag, fetch halted until an aligned redirect).
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);

  // Pointers carry one extra wrap bit so full (alloc == DEPTH) and empty are distinguishable.
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // wr: next slot to allocate at grant; fill: next slot awaiting rdata; rd: head handed to decode.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;
  // Responses still owed by memory for requests flushed by a redirect.
  logic [PW-1:0] discard;

  logic [PW-1:0] alloc;
  logic [PW-1:0] inflight;
  logic [PW-1:0] avail;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic        grant;
  logic        fill_en;
  logic        pop;
  logic        misaligned;
  logic [31:0] redirect_tgt;

  assign alloc    = wr_ptr - rd_ptr;
  assign inflight = wr_ptr - fill_ptr;
  assign avail    = fill_ptr - rd_ptr;

`ifdef IFETCH_MISALIGN_EN
  // Misaligned targets are passed through raw so the trap logic sees the real address.
  assign redirect_tgt     = redirect_pc;
  assign fetch_misaligned = misaligned;

  // Sticky misaligned flag: every redirect re-evaluates it, nothing else touches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else if (redirect) begin
      misaligned <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  // Without checking, the low bits are simply forced to a word boundary.
  logic unused_lsbs;
  assign unused_lsbs  = ^redirect_pc[1:0];
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign misaligned   = 1'b0;
`endif

  // Request whenever a slot is free; uses registered alloc so a pop only frees a slot next cycle.
  always_comb begin
    imem_req = !rst && !redirect && !misaligned && (alloc < DEPTH_P);
  end

  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // A response is kept only when no flushed responses are still owed and no redirect is flushing now.
  assign fill_en = imem_rvalid && (discard == '0) && !redirect;

  // Decode sees the queue head; a redirect cycle masks it so nothing stale escapes.
  always_comb begin
    instr_valid = !rst && !redirect && (avail != '0);
    instr       = instr_mem[rd_ptr[IW-1:0]];
    instr_pc    = pc_mem[rd_ptr[IW-1:0]];
  end

  assign pop = instr_valid && instr_ready;

  // Next pc for the external pc register: reset, then redirect, then advance on grant, else hold.
  always_comb begin
    next_pc = pc;
    if (rst) begin
      next_pc = 32'h0;
    end else if (redirect) begin
      next_pc = redirect_tgt;
    end else if (grant) begin
      next_pc = pc + 32'd4;
    end
  end

  // Queue pointers and discard count; a redirect wins over grant, fill and pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      discard  <= '0;
    end else if (redirect) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      // Every request still in flight will answer later; the one answering now is dropped here.
      discard  <= discard + inflight - PW'(imem_rvalid);
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (imem_rvalid) begin
        if (discard != '0) begin
          discard <= discard - PTR_ONE;
        end else begin
          fill_ptr <= fill_ptr + PTR_ONE;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Entry payloads: pc captured at grant, instruction word captured at fill; held until overwritten.
  always_ff @(posedge clk) begin
    if (grant) begin
      pc_mem[wr_ptr[IW-1:0]] <= pc;
    end
    if (fill_en) begin
      instr_mem[fill_ptr[IW-1:0]] <= imem_rdata;
    end
  end

  // Memory must never answer when nothing is outstanding.
  a_rvalid_protocol: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (inflight == '0) && (discard == '0)));

  // Allocation can never run past the queue size.
  a_alloc_bound: assert property (@(posedge clk) disable iff (rst)
    alloc <= DEPTH_P);

endmodule
